// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns a debounced, active-low key level into one-cycle event pulses:
// click, double-click, long-press and auto-repeat while held after a long
// press. One five-state FSM and one shared 24-bit interval counter do all
// the timing; every output is a flop.
//
// Handshake note: this block has no valid/ready interfaces. Each pulse is a
// single-cycle strobe with no back-pressure, so consumers must sample it
// every cycle.

module key_event_decoder #(
  parameter logic [23:0] LONG_CNT   = 24'd12000000,
  parameter logic [23:0] DCLICK_CNT = 24'd3600000,
  parameter logic [23:0] REPEAT_CNT = 24'd2400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_level,
  output logic       click_pulse,
  output logic       dclick_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // FSM encoding; IDLE is zero so busy is simply "state is non-zero".
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_LONG   = 3'd4;

  // The counter starts at 0 on the edge that enters a state, so the k-th
  // edge after entry sees cnt == k-1. Comparing with PARAM-1 therefore
  // fires exactly PARAM edges after entry.
  localparam logic [23:0] LONG_LAST   = LONG_CNT   - 24'd1;
  localparam logic [23:0] DCLICK_LAST = DCLICK_CNT - 24'd1;
  localparam logic [23:0] REPEAT_LAST = REPEAT_CNT - 24'd1;

  logic        key_d;
  logic        fall;
  logic        rise;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [23:0] cnt;
  logic        cnt_clr;
  logic        click_nxt;
  logic        dclick_nxt;
  logic        long_nxt;
  logic        repeat_nxt;

  // key_d resets to 1 (released). A key held low through reset release is
  // therefore seen as a fresh press on the first edge.
  assign fall = key_d & ~key_level;
  assign rise = ~key_d & key_level;

  assign state_dbg = state;

  // Delay the key level by one clock for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d <= 1'b1;
    end else begin
      key_d <= key_level;
    end
  end

  // Next-state and pulse decode; a key edge always beats a counter expiry.
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    click_nxt  = 1'b0;
    dclick_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_nxt = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (rise) begin
          state_nxt = ST_WAIT2;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG;
        end
      end
      ST_WAIT2: begin
        if (fall) begin
          state_nxt = ST_PRESS2;
        end else if (cnt == DCLICK_LAST) begin
          click_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        // No long-press detection here: the second press only ends in a
        // double-click, however long it is held.
        if (rise) begin
          dclick_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_LONG: begin
        if (rise) begin
          state_nxt = ST_IDLE;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Every state entry restarts the interval counter.
    if (state_nxt != state) begin
      cnt_clr = 1'b1;
    end
  end

  // FSM state and shared interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 24'd0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) begin
        cnt <= 24'd0;
      end else begin
        cnt <= cnt + 24'd1;
      end
    end
  end

  // Registered outputs; busy follows the state being entered so it falls
  // in the same cycle as the final pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_pulse  <= 1'b0;
      dclick_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      click_pulse  <= click_nxt;
      dclick_pulse <= dclick_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short intervals
// (LONG=20, DCLICK=8, REPEAT=5). Inputs change on the falling clock edge;
// a monitor on the falling edge records every pulse with its edge number.

module tb_key_event_decoder;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_level = 1'b1;
  logic       click_pulse;
  logic       dclick_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CNT   (24'd20),
    .DCLICK_CNT (24'd8),
    .REPEAT_CNT (24'd5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_level    (key_level),
    .click_pulse  (click_pulse),
    .dclick_pulse (dclick_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Edge counter: after the k-th rising edge, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int   n_click, n_dclick, n_long, n_rep;
  int   last_click, last_dclick, last_long;
  int   busy_fall;
  int   overlap;
  int   rep_q[$];
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (click_pulse)  begin n_click++;  last_click  = cyc; end
    if (dclick_pulse) begin n_dclick++; last_dclick = cyc; end
    if (long_pulse)   begin n_long++;   last_long   = cyc; end
    if (repeat_pulse) begin n_rep++;    rep_q.push_back(cyc); end
    if ((32'(click_pulse) + 32'(dclick_pulse) + 32'(long_pulse) + 32'(repeat_pulse)) > 1) overlap++;
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  task automatic clear_mon();
    n_click = 0; n_dclick = 0; n_long = 0; n_rep = 0;
    last_click = -1; last_dclick = -1; last_long = -1;
    busy_fall = -1; overlap = 0;
    rep_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; the level is sampled by the next n rising edges.
  task automatic drive(input logic lvl, input int n);
    key_level = lvl;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (click_pulse !== 1'b0) begin errors++; $display("FAIL rst_click: got %b expected 0", click_pulse); end
    checks++; if (dclick_pulse !== 1'b0) begin errors++; $display("FAIL rst_dclick: got %b expected 0", dclick_pulse); end
    checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL rst_long: got %b expected 0", long_pulse); end
    checks++; if (repeat_pulse !== 1'b0) begin errors++; $display("FAIL rst_repeat: got %b expected 0", repeat_pulse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    clear_mon();
    rst_n = 1'b1;
    drive(1'b1, 50);
    checks++; if ((n_click + n_dclick + n_long + n_rep) !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", n_click + n_dclick + n_long + n_rep); end
    checks++; if (busy_fall !== -1 || busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got busy=%b fall=%0d expected busy=0 fall=-1", busy, busy_fall); end
  endtask

  task automatic test_single_click();
    int r0;
    clear_mon();
    drive(1'b0, 5);
    r0 = cyc + 1;
    drive(1'b1, 20);
    checks++; if (n_click !== 1) begin errors++; $display("FAIL click_count: got %0d expected 1", n_click); end
    checks++; if (last_click !== r0 + 8) begin errors++; $display("FAIL click_edge: got %0d expected %0d", last_click, r0 + 8); end
    checks++; if (busy_fall !== r0 + 8) begin errors++; $display("FAIL click_busy_fall: got %0d expected %0d", busy_fall, r0 + 8); end
    checks++; if ((n_dclick + n_long + n_rep) !== 0) begin errors++; $display("FAIL click_others: got %0d expected 0", n_dclick + n_long + n_rep); end
  endtask

  task automatic test_double_click();
    int r0b;
    clear_mon();
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 4);
    r0b = cyc + 1;
    drive(1'b1, 20);
    checks++; if (n_dclick !== 1) begin errors++; $display("FAIL dclick_count: got %0d expected 1", n_dclick); end
    checks++; if (last_dclick !== r0b) begin errors++; $display("FAIL dclick_edge: got %0d expected %0d", last_dclick, r0b); end
    checks++; if (n_click !== 0) begin errors++; $display("FAIL dclick_no_click: got %0d expected 0", n_click); end
    checks++; if (busy_fall !== r0b) begin errors++; $display("FAIL dclick_busy_fall: got %0d expected %0d", busy_fall, r0b); end
    checks++; if ((n_long + n_rep) !== 0) begin errors++; $display("FAIL dclick_others: got %0d expected 0", n_long + n_rep); end
  endtask

  task automatic test_long_repeat();
    int e0, r0;
    int exp_rep[3];
    clear_mon();
    e0 = cyc + 1;
    drive(1'b0, 37);
    r0 = cyc + 1;
    drive(1'b1, 15);
    exp_rep[0] = e0 + 25; exp_rep[1] = e0 + 30; exp_rep[2] = e0 + 35;
    checks++; if (n_long !== 1 || last_long !== e0 + 20) begin errors++; $display("FAIL long_edge: got n=%0d at %0d expected n=1 at %0d", n_long, last_long, e0 + 20); end
    checks++; if (rep_q.size() !== 3) begin errors++; $display("FAIL repeat_count: got %0d expected 3", rep_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < rep_q.size()) begin
        checks++; if (rep_q[i] !== exp_rep[i]) begin errors++; $display("FAIL repeat_edge%0d: got %0d expected %0d", i, rep_q[i], exp_rep[i]); end
      end
    end
    checks++; if ((n_click + n_dclick) !== 0) begin errors++; $display("FAIL long_release_pulse: got %0d expected 0", n_click + n_dclick); end
    checks++; if (busy_fall !== r0) begin errors++; $display("FAIL long_busy_fall: got %0d expected %0d", busy_fall, r0); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL long_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_boundaries();
    clear_mon();
    drive(1'b0, 20);     // lows at E0..E19, rise sampled at E20
    drive(1'b1, 1);
    checks++; if (state_dbg !== ST_WAIT2) begin errors++; $display("FAIL bnd_rise_state: got %0d expected %0d", state_dbg, ST_WAIT2); end
    checks++; if (n_long !== 0) begin errors++; $display("FAIL bnd_no_long: got %0d expected 0", n_long); end
    drive(1'b1, 7);      // highs R0..R7, fall sampled at R8
    drive(1'b0, 1);
    checks++; if (state_dbg !== ST_PRESS2) begin errors++; $display("FAIL bnd_fall_state: got %0d expected %0d", state_dbg, ST_PRESS2); end
    checks++; if (n_click !== 0) begin errors++; $display("FAIL bnd_no_click: got %0d expected 0", n_click); end
    drive(1'b0, 2);
    drive(1'b1, 5);
    checks++; if (n_dclick !== 1) begin errors++; $display("FAIL bnd_dclick: got %0d expected 1", n_dclick); end
    checks++; if (state_dbg !== ST_IDLE || n_long !== 0) begin errors++; $display("FAIL bnd_end: got state=%0d long=%0d expected state=0 long=0", state_dbg, n_long); end
  endtask

  task automatic test_reset_mid_long();
    int f;
    clear_mon();
    drive(1'b0, 27);     // lows at E0..E26
    @(posedge clk);      // E27
    #1;
    checks++; if (busy !== 1'b1 || n_long !== 1 || n_rep !== 1) begin errors++; $display("FAIL mid_pre_reset: got busy=%b long=%0d rep=%0d expected 1 1 1", busy, n_long, n_rep); end
    rst_n = 1'b0;
    #1;
    checks++; if ({click_pulse, dclick_pulse, long_pulse, repeat_pulse, busy} !== 5'b0) begin errors++; $display("FAIL mid_reset_outputs: got %b expected 00000", {click_pulse, dclick_pulse, long_pulse, repeat_pulse, busy}); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", state_dbg); end
    @(negedge clk);
    @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    f = cyc + 1;
    drive(1'b0, 25);
    checks++; if (n_long !== 1 || last_long !== f + 20) begin errors++; $display("FAIL mid_new_long: got n=%0d at %0d expected n=1 at %0d", n_long, last_long, f + 20); end
    checks++; if (n_rep !== 0) begin errors++; $display("FAIL mid_new_repeat: got %0d expected 0", n_rep); end
    drive(1'b1, 10);
    checks++; if (busy !== 1'b0 || (n_click + n_dclick) !== 0) begin errors++; $display("FAIL mid_release: got busy=%b pulses=%0d expected 0 0", busy, n_click + n_dclick); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_click();
    test_double_click();
    test_long_repeat();
    test_boundaries();
    test_reset_mid_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
